// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which cache issued the outstanding reads
package mem_arbiter_pkg;

    localparam int MEM_LATENCY_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_out_cnt.sv
// Outstanding-read counter for the memory arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : one read issued this cycle
//   dec        : one read returned this cycle
//   cnt        : reads currently in flight
//   zero_next  : counter will be zero after this edge
//   full       : cnt has reached MAX_CNT
module mem_arb_out_cnt #(
    parameter int MAX_CNT = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero_next,
    output logic             full
);

    logic [CNT_W-1:0] cnt_n;

    assign full = (cnt == CNT_W'(MAX_CNT));

    always_comb begin
        cnt_n = cnt;
        if (inc && !dec) begin
            if (!full) cnt_n = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) cnt_n = cnt - CNT_W'(1);
        end
        zero_next = (cnt_n == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_n;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the fixed-latency main memory between I-cache and D-cache.
//   clk, rst_n                      : clock, synchronous active-low reset
//   i_req/i_en/i_addr               : I-cache ownership request and read issue
//   i_gnt/i_data_valid              : I-cache grant and steered read-valid
//   d_req/d_en/d_wr/d_addr/d_wdata  : D-cache ownership request and access
//   d_gnt/d_data_valid              : D-cache grant and steered read-valid
//   mem_en/mem_wr/mem_addr/mem_wdata: memory command, driven from the owner
//   mem_data_valid                  : memory read-return strobe
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_data_valid,
    input  logic              d_req,
    input  logic              d_en,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_t        state, state_n;
    owner_t            owner, owner_n, last, last_n;
    logic [CNT_W-1:0]  out_cnt;
    logic              cnt_zero_next, cnt_full, cnt_inc, cnt_dec;
    logic              own_req, own_en, own_wr, issue_ok, steer;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    mem_arb_out_cnt #(
        .MAX_CNT (MEM_LATENCY),
        .CNT_W   (CNT_W)
    ) u_out_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (cnt_inc),
        .dec       (cnt_dec),
        .cnt       (out_cnt),
        .zero_next (cnt_zero_next),
        .full      (cnt_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWN_I;
            last  <= OWN_I;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
        end
    end

    // D wins a fresh contention; I wins if D had the previous grant.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        unique case (state)
            IDLE: begin
                if (d_req && !(i_req && last == OWN_D)) begin
                    state_n = GNT_D;
                    owner_n = OWN_D;
                    last_n  = OWN_D;
                end else if (i_req) begin
                    state_n = GNT_I;
                    owner_n = OWN_I;
                    last_n  = OWN_I;
                end
            end
            GNT_I: if (!i_req) state_n = cnt_zero_next ? IDLE : DRAIN;
            GNT_D: if (!d_req) state_n = cnt_zero_next ? IDLE : DRAIN;
            DRAIN: if (cnt_zero_next) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        own_req   = 1'b0;
        own_en    = 1'b0;
        own_wr    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        unique case (state)
            GNT_I: begin
                own_req  = i_req;
                own_en   = i_en;
                own_addr = i_addr;
            end
            GNT_D: begin
                own_req   = d_req;
                own_en    = d_en;
                own_wr    = d_wr;
                own_addr  = d_addr;
                own_wdata = d_wdata;
            end
            default: ;
        endcase

        // A read at the limit still issues if a return frees a slot this cycle.
        issue_ok  = rst_n && own_req && own_en && (own_wr || !cnt_full || mem_data_valid);
        mem_en    = issue_ok;
        mem_wr    = issue_ok && own_wr;
        mem_addr  = issue_ok ? own_addr  : '0;
        mem_wdata = issue_ok ? own_wdata : '0;

        i_gnt = rst_n && (state == GNT_I);
        d_gnt = rst_n && (state == GNT_D);

        // Returns with nothing outstanding belong to nobody (e.g. after a reset).
        steer        = rst_n && mem_data_valid && (out_cnt != '0);
        i_data_valid = steer && (owner == OWN_I);
        d_data_valid = steer && (owner == OWN_D);

        cnt_inc = issue_ok && !own_wr;
        cnt_dec = steer;
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(i_gnt && d_gnt));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_en, d_req, d_en, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_data_valid, d_gnt, d_data_valid;
    logic        mem_en, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .MEM_LATENCY (L)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_en           (i_en),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_data_valid   (i_data_valid),
        .d_req          (d_req),
        .d_en           (d_en),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_data_valid   (d_data_valid),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = L;
    bit stray_v = 1'b0;
    int ret_q[$];

    // Reference: who holds memory (0 nobody, 1 I, 2 D), whether the holder has
    // let go and is only waiting for returns, who issued the reads in flight,
    // who won last, and how many reads are in flight.
    int m_hold = 0;
    bit m_drain = 1'b0;
    int m_own = 1;
    int m_last = 1;
    int m_cnt = 0;
    logic [37:0] e_vec;
    bit e_issue_rd, e_deliv;

    function automatic void model_eval();
        bit ig, dg, act, rd, blk, en, wr, idv, ddv;
        logic [15:0] a, w;
        ig  = (m_hold == 1) && !m_drain;
        dg  = (m_hold == 2) && !m_drain;
        act = (ig && i_req && i_en) || (dg && d_req && d_en);
        rd  = !(dg && d_wr);
        blk = act && rd && (m_cnt == L) && !mem_data_valid;
        en  = act && !blk;
        wr  = en && dg && d_wr;
        a   = !en ? 16'h0 : (dg ? d_addr : i_addr);
        w   = (en && dg) ? d_wdata : 16'h0;
        e_deliv    = mem_data_valid && (m_cnt > 0);
        e_issue_rd = en && rd;
        idv = e_deliv && (m_own == 1);
        ddv = e_deliv && (m_own == 2);
        if (!rst_n) begin
            ig = 0; dg = 0; idv = 0; ddv = 0; en = 0; wr = 0; a = '0; w = '0;
            e_issue_rd = 0; e_deliv = 0;
        end
        e_vec = {ig, dg, idv, ddv, en, wr, a, w};
    endfunction

    function automatic void model_update();
        if (!rst_n) begin
            m_hold = 0; m_drain = 0; m_cnt = 0; m_last = 1; m_own = 1;
        end else begin
            m_cnt = m_cnt + int'(e_issue_rd) - int'(e_deliv);
            if (m_hold == 0) begin
                if (d_req && !(i_req && m_last == 2)) begin
                    m_hold = 2; m_own = 2; m_last = 2;
                end else if (i_req) begin
                    m_hold = 1; m_own = 1; m_last = 1;
                end
            end else if (!m_drain) begin
                if (!((m_hold == 1) ? i_req : d_req)) begin
                    if (m_cnt == 0) m_hold = 0;
                    else            m_drain = 1;
                end
            end else if (m_cnt == 0) begin
                m_hold = 0; m_drain = 0;
            end
        end
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    // One clock: called at negedge with inputs set; checks mid-cycle.
    task automatic tick();
        logic [37:0] obs;
        mem_data_valid = stray_v || (ret_q.size() > 0 && ret_q[0] == cyc);
        #1;
        model_eval();
        obs = {i_gnt, d_gnt, i_data_valid, d_data_valid, mem_en, mem_wr, mem_addr, mem_wdata};
        checks++;
        assert (obs === e_vec) else begin
            errors++;
            $error("FAIL out@%0d obs=%h exp=%h", cyc, obs, e_vec);
        end
        @(posedge clk);
        model_update();
        if (ret_q.size() > 0 && ret_q[0] == cyc) void'(ret_q.pop_front());
        if (e_issue_rd) ret_q.push_back(cyc + lat);
        cyc++;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 0; i_req = 0; i_en = 0; i_addr = '0;
        d_req = 0; d_en = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        mem_data_valid = 0;
        @(negedge clk);

        // Reset
        ticks(2);
        chk1("rst_i_gnt", i_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        rst_n = 1;

        // I fill of 8 reads, then drain
        i_req = 1; tick();
        chk1("i_gnt_next", i_gnt, 1'b1);
        for (int k = 0; k < 8; k++) begin
            i_en = 1; i_addr = 16'h0100 + 16'(2 * k); tick();
        end
        i_en = 0; i_req = 0; tick();
        chk1("i_drain_no_gnt", i_gnt, 1'b0);
        ticks(6);

        // Simultaneous requests from reset, then alternation
        rst_n = 0; tick(); rst_n = 1;
        i_req = 1; d_req = 1; tick();
        chk1("d_first", d_gnt, 1'b1);
        chk1("i_waits", i_gnt, 1'b0);
        d_en = 1; d_wr = 0; d_addr = 16'h3000; tick();
        d_addr = 16'h3002; tick();
        d_en = 0; d_req = 0; tick();
        ticks(5);
        chk1("i_after_d", i_gnt, 1'b1);
        d_req = 1;
        i_req = 0; tick(); i_req = 1; tick();
        chk1("alt_d", d_gnt, 1'b1);
        d_req = 0; tick(); d_req = 1; tick();
        chk1("alt_i", i_gnt, 1'b1);
        i_req = 0; tick(); i_req = 1; tick();
        chk1("alt_d2", d_gnt, 1'b1);
        i_req = 0; d_req = 0; ticks(2);

        // D write-through
        d_req = 1; tick();
        d_en = 1; d_wr = 1; d_addr = 16'h2000; d_wdata = 16'hBEEF;
        #1;
        chk1("wr_en", mem_en, 1'b1);
        chk1("wr_wr", mem_wr, 1'b1);
        chk1("wr_addr", mem_addr == 16'h2000, 1'b1);
        chk1("wr_data", mem_wdata == 16'hBEEF, 1'b1);
        tick();
        d_en = 0; d_wr = 0; d_req = 0; tick();
        chk1("wr_release", d_gnt, 1'b0);
        tick();

        // d_req pulse during an I fill is not granted
        i_req = 1; tick();
        for (int k = 0; k < 4; k++) begin
            i_en = 1; i_addr = 16'h0400 + 16'(2 * k); d_req = (k == 1); tick();
        end
        d_req = 0; i_en = 0; i_req = 0; ticks(8);
        chk1("pulse_no_dgnt", d_gnt, 1'b0);

        // Outstanding limit with slow returns
        lat = L + 2;
        i_req = 1; tick();
        for (int k = 0; k < 7; k++) begin
            i_en = 1; i_addr = 16'h0500 + 16'(k);
            if (k == 4 || k == 6) begin
                mem_data_valid = (ret_q.size() > 0 && ret_q[0] == cyc);
                #1;
                chk1((k == 4) ? "blocked_5th" : "unblocked", mem_en, (k == 6));
            end
            tick();
        end
        i_en = 0; i_req = 0; ticks(12);
        lat = L;

        // Stray valid in IDLE
        stray_v = 1;
        mem_data_valid = 1; #1;
        chk1("stray_i", i_data_valid, 1'b0);
        chk1("stray_d", d_data_valid, 1'b0);
        ticks(2);
        stray_v = 0;

        // Reset mid-fill with 3 outstanding
        i_req = 1; tick();
        for (int k = 0; k < 3; k++) begin
            i_en = 1; i_addr = 16'h0600 + 16'(k); tick();
        end
        i_en = 0; rst_n = 0; #1;
        chk1("rst_mid_gnt", i_gnt, 1'b0);
        tick();
        rst_n = 1; i_req = 0; ticks(6);
        i_req = 1; tick();
        chk1("regrant", i_gnt, 1'b1);
        i_en = 1; i_addr = 16'h0700; tick();
        i_addr = 16'h0702; tick();
        i_en = 0; i_req = 0; ticks(8);

        // Randomized traffic, normal then slow returns
        for (int r = 0; r < 600; r++) begin
            if (r == 300) begin
                i_req = 0; d_req = 0; i_en = 0; d_en = 0;
                ticks(14);
                lat = L + 2;
            end
            if ($urandom_range(7) == 0) i_req = !i_req;
            if ($urandom_range(7) == 0) d_req = !d_req;
            i_en    = 1'($urandom_range(1));
            d_en    = 1'($urandom_range(1));
            d_wr    = ($urandom_range(3) == 0);
            i_addr  = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
            stray_v = ($urandom_range(31) == 0);
            tick();
        end
        stray_v = 0; i_req = 0; d_req = 0; i_en = 0; d_en = 0;
        ticks(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
